// File: rtl/dma_dev_port.sv
// Device-side front end for dma_controller: issues one request per descriptor,
// then runs the dev_ack/dma_ack word handshake. Writes stream from a source; reads buffer into a FIFO.
module dma_dev_port #(
  parameter int ADD_LEN   = 16,
  parameter int DATA_LEN  = 16,
  parameter int BUF_DEPTH = 3,
  parameter int TIMEOUT   = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_start,
  input  logic                cfg_rd_wr,
  input  logic [ADD_LEN:0]    cfg_addr,
  input  logic [ADD_LEN-1:0]  cfg_words,
  input  logic [DATA_LEN-1:0] src_data,
  input  logic                src_valid,
  output logic                src_ready,
  output logic [DATA_LEN-1:0] snk_data,
  output logic                snk_valid,
  input  logic                snk_ready,
  output logic                busy,
  output logic                done,
  output logic                err_align,
  output logic                err_zero,
  output logic                err_timeout,
  output logic                err_overrun,
  output logic [ADD_LEN-1:0]  xfer_cnt,
  output logic                rqst,
  output logic                rd_wr,
  output logic [ADD_LEN-1:0]  num_words,
  output logic [ADD_LEN:0]    start_addr,
  output logic                dev_ack,
  output logic [DATA_LEN-1:0] dev_in,
  input  logic                dma_ack,
  input  logic                end_flag,
  input  logic [DATA_LEN-1:0] dev_out
);

  localparam int DEPTH = 2 ** BUF_DEPTH;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [BUF_DEPTH:0] FULL_CNT = (BUF_DEPTH + 1)'(DEPTH);
  localparam logic [BUF_DEPTH:0] ACK_MAX  = (BUF_DEPTH + 1)'(DEPTH - 2);
  localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, WR_XFER, RD_XFER, WAIT_END, GAP, HALT
  } state_t;

  state_t state, state_nxt;

  logic [DATA_LEN-1:0]  mem [DEPTH];
  logic [BUF_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [BUF_DEPTH:0]   fifo_count;
  logic [WD_W-1:0]      wdog;
  logic                 err_done;

  logic start_acc, cfg_bad, in_xfer, stall, wdog_to, last_word;
  logic fifo_full, push_req, overrun, push, pop;

  assign start_acc = (state == IDLE) && cfg_start;
  assign cfg_bad   = cfg_addr[0] || (cfg_words == '0);
  assign in_xfer   = state inside {WR_XFER, RD_XFER, WAIT_END};
  // A sink holding off the FIFO is back-pressure, not a dead controller.
  assign stall     = snk_valid && !snk_ready;
  assign wdog_to   = in_xfer && !dma_ack && !end_flag && !stall && (wdog == WD_LAST);
  assign last_word = (xfer_cnt + ADD_LEN'(1)) == num_words;

  assign fifo_full = (fifo_count == FULL_CNT);
  assign push_req  = (state == RD_XFER) && dma_ack;
  assign overrun   = push_req && (fifo_full || (xfer_cnt == num_words));
  assign push      = push_req && !overrun;
  assign snk_valid = (fifo_count != '0);
  assign snk_data  = mem[rd_ptr];
  assign pop       = snk_valid && snk_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (cfg_start && !cfg_bad) state_nxt = REQ;
      REQ:      state_nxt = rd_wr ? RD_XFER : WR_XFER;
      WR_XFER: begin
        if (end_flag)                  state_nxt = GAP;
        else if (dma_ack && last_word) state_nxt = WAIT_END;
        else if (wdog_to)              state_nxt = HALT;
      end
      RD_XFER, WAIT_END: begin
        if (end_flag)     state_nxt = GAP;
        else if (wdog_to) state_nxt = HALT;
      end
      GAP:      state_nxt = IDLE;
      HALT:     state_nxt = HALT;
      default:  state_nxt = IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    rqst      = 1'b0;
    dev_ack   = 1'b0;
    src_ready = 1'b0;
    dev_in    = '0;
    busy      = (state != IDLE);
    done      = err_done || (state == GAP);
    case (state)
      REQ:     rqst = 1'b1;
      WR_XFER: begin
        dev_ack   = src_valid;
        dev_in    = src_data;
        src_ready = dma_ack;
      end
      RD_XFER: dev_ack = (fifo_count <= ACK_MAX);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_wr       <= 1'b0;
      num_words   <= '0;
      start_addr  <= '0;
      xfer_cnt    <= '0;
      err_align   <= 1'b0;
      err_zero    <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      err_done    <= 1'b0;
      wdog        <= '0;
    end else begin
      err_done <= start_acc && cfg_bad;
      if (start_acc) begin
        rd_wr       <= cfg_rd_wr;
        num_words   <= cfg_words;
        start_addr  <= cfg_addr;
        xfer_cnt    <= '0;
        err_align   <= cfg_addr[0];
        err_zero    <= (cfg_words == '0);
        err_timeout <= 1'b0;
        err_overrun <= 1'b0;
      end else begin
        if (((state == WR_XFER) && dma_ack) || push) xfer_cnt <= xfer_cnt + ADD_LEN'(1);
        if (wdog_to) err_timeout <= 1'b1;
        if (overrun) err_overrun <= 1'b1;
      end
      if (!in_xfer || dma_ack || end_flag) wdog <= '0;
      else if (!stall)                     wdog <= wdog + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + BUF_DEPTH'(1);
      if (pop)  rd_ptr <= rd_ptr + BUF_DEPTH'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the buffer is small, so it is reset to zero; a larger RAM would leave contents unreset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= dev_out;
    end
  end

endmodule

// File: tb/tb_dma_dev_port.sv
// Directed bench for dma_dev_port: write, stalled read, config errors, short read,
// overrun, reset mid-transfer and watchdog halt, checked against hand-computed values.
module tb_dma_dev_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_start, cfg_rd_wr;
  logic [16:0] cfg_addr;
  logic [15:0] cfg_words;
  logic [15:0] src_data;
  logic        src_valid, src_ready;
  logic [15:0] snk_data;
  logic        snk_valid, snk_ready;
  logic        busy, done;
  logic        err_align, err_zero, err_timeout, err_overrun;
  logic [15:0] xfer_cnt;
  logic        rqst, rd_wr;
  logic [15:0] num_words;
  logic [16:0] start_addr;
  logic        dev_ack;
  logic [15:0] dev_in;
  logic        dma_ack, end_flag;
  logic [15:0] dev_out;

  int n_checks = 0;
  int n_pass   = 0;

  dma_dev_port dut (
    .clk(clk), .reset(reset),
    .cfg_start(cfg_start), .cfg_rd_wr(cfg_rd_wr), .cfg_addr(cfg_addr), .cfg_words(cfg_words),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .busy(busy), .done(done),
    .err_align(err_align), .err_zero(err_zero), .err_timeout(err_timeout), .err_overrun(err_overrun),
    .xfer_cnt(xfer_cnt), .rqst(rqst), .rd_wr(rd_wr), .num_words(num_words), .start_addr(start_addr),
    .dev_ack(dev_ack), .dev_in(dev_in),
    .dma_ack(dma_ack), .end_flag(end_flag), .dev_out(dev_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic rw, input logic [16:0] addr, input logic [15:0] words);
    cfg_start = 1'b1; cfg_rd_wr = rw; cfg_addr = addr; cfg_words = words;
    tick();
    cfg_start = 1'b0;
  endtask

  logic [3:0] errs;
  assign errs = {err_align, err_zero, err_timeout, err_overrun};

  initial begin
    logic pend, saw_ack6;
    int   issued, recv;

    reset = 1'b1; cfg_start = 1'b0; cfg_rd_wr = 1'b0; cfg_addr = '0; cfg_words = '0;
    src_data = '0; src_valid = 1'b0; snk_ready = 1'b0;
    dma_ack = 1'b0; end_flag = 1'b0; dev_out = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_ctrl", {rqst, busy, done, dev_ack, src_ready, snk_valid}, 6'b0);
    check("rst_errs", errs, 4'b0);
    check("rst_cnt", xfer_cnt, 16'h0);
    check("rst_desc", {rd_wr, num_words, start_addr}, 34'h0);
    check("rst_dev_in", dev_in, 16'h0);

    // Write transfer, four words with a gap in dma_ack.
    src_valid = 1'b1; src_data = 16'h1111;
    start_job(1'b0, 17'h0200, 16'd4);
    check("wr_rqst", {rqst, busy, dev_ack}, 3'b110);
    check("wr_desc", {rd_wr, num_words, start_addr}, {1'b0, 16'd4, 17'h0200});
    tick();
    check("wr_rqst_once", rqst, 1'b0);
    check("wr_dev_ack", dev_ack, 1'b1);
    check("wr_dev_in", dev_in, 16'h1111);
    check("wr_ready_idle", src_ready, 1'b0);
    begin
      logic [4:0] pat = 5'b11101;
      int k = 0;
      for (int i = 0; i < 5; i++) begin
        dma_ack = pat[i];
        src_data = 16'h1111 + 16'(i);
        #1;
        check("wr_ready_eq_ack", src_ready, pat[i]);
        check("wr_dev_in_follow", dev_in, 16'h1111 + 16'(i));
        tick();
        if (pat[i]) k++;
        check("wr_cnt", xfer_cnt, k);
      end
    end
    dma_ack = 1'b0;
    #1;
    check("wr_wait_end_ack", {dev_ack, src_ready}, 2'b00);
    tick();
    end_flag = 1'b1;
    #1;
    check("wr_no_early_done", done, 1'b0);
    tick();
    end_flag = 1'b0;
    check("wr_done", {done, busy}, 2'b11);
    tick();
    check("wr_done_one", {done, busy}, 2'b00);
    check("wr_final_cnt", xfer_cnt, 16'd4);
    check("wr_errs", errs, 4'b0);

    // Configuration errors.
    src_valid = 1'b0;
    start_job(1'b0, 17'h0201, 16'd4);
    check("align_flags", errs, 4'b1000);
    check("align_done", {done, rqst, busy}, 3'b100);
    tick();
    check("align_idle", {done, rqst, busy}, 3'b000);
    start_job(1'b0, 17'h0200, 16'd0);
    check("zero_flags", errs, 4'b0100);
    check("zero_done", {done, rqst, busy}, 3'b100);
    tick();

    // Read of 12 words with a 20-cycle sink stall; controller answers dev_ack one cycle late.
    start_job(1'b1, 17'h0400, 16'd12);
    check("rd_errs_cleared", errs, 4'b0);
    check("rd_rqst", {rqst, rd_wr}, 2'b11);
    tick();
    pend = 1'b0; issued = 0; recv = 0; saw_ack6 = 1'b0;
    for (int cyc = 0; cyc < 200 && recv < 12; cyc++) begin
      snk_ready = (cyc >= 20);
      dma_ack = pend;
      if (pend) begin
        dev_out = 16'hA000 + 16'(issued);
        issued++;
      end else begin
        dev_out = 16'hDEAD;
      end
      #1;
      if (cyc < 20 && xfer_cnt == 16'd6) saw_ack6 = dev_ack;
      if (cyc == 19) begin
        check("rd_stall_cnt", xfer_cnt, 16'd8);
        check("rd_stall_ack_low", dev_ack, 1'b0);
        check("rd_stall_no_ovr", err_overrun, 1'b0);
      end
      if (snk_valid && snk_ready) begin
        check("rd_word", snk_data, 16'hA000 + 16'(recv));
        recv++;
      end
      pend = dev_ack && (issued < 12);
      tick();
    end
    dma_ack = 1'b0;
    check("rd_ack_at6", saw_ack6, 1'b1);
    check("rd_recv", recv, 12);
    check("rd_cnt", xfer_cnt, 16'd12);
    check("rd_errs", errs, 4'b0);
    check("rd_empty", snk_valid, 1'b0);
    end_flag = 1'b1;
    tick();
    end_flag = 1'b0;
    check("rd_done", done, 1'b1);
    tick();
    check("rd_idle", {done, busy}, 2'b00);

    // Short read: end_flag after 3 of 5 words, sink not draining.
    snk_ready = 1'b0;
    start_job(1'b1, 17'h0010, 16'd5);
    tick();
    dma_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dev_out = 16'hB000 + 16'(i);
      tick();
    end
    dma_ack = 1'b0;
    check("short_cnt", xfer_cnt, 16'd3);
    end_flag = 1'b1;
    tick();
    end_flag = 1'b0;
    check("short_done", done, 1'b1);
    check("short_cnt_kept", xfer_cnt, 16'd3);
    check("short_errs", errs, 4'b0);
    tick();
    check("short_undrained", {snk_valid, snk_data}, {1'b1, 16'hB000});

    // Overrun: third dma_ack on a 2-word read is dropped; FIFO cleared by the start.
    start_job(1'b1, 17'h0020, 16'd2);
    check("ovr_fifo_cleared", snk_valid, 1'b0);
    tick();
    dma_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dev_out = 16'hC000 + 16'(i);
      tick();
    end
    dma_ack = 1'b0;
    check("ovr_flag", err_overrun, 1'b1);
    check("ovr_cnt", xfer_cnt, 16'd2);
    snk_ready = 1'b1;
    #1;
    check("ovr_word0", snk_data, 16'hC000);
    tick();
    check("ovr_word1", snk_data, 16'hC001);
    tick();
    check("ovr_not_pushed", snk_valid, 1'b0);
    snk_ready = 1'b0;
    end_flag = 1'b1;
    tick();
    end_flag = 1'b0;
    check("ovr_done", done, 1'b1);
    tick();

    // Reset during WR_XFER.
    src_valid = 1'b1; src_data = 16'h5A5A;
    start_job(1'b0, 17'h0300, 16'd4);
    tick();
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    check("mid_cnt", xfer_cnt, 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_ctrl", {rqst, busy, done, dev_ack, src_ready}, 5'b0);
    check("mid_regs", {xfer_cnt, num_words, start_addr, dev_in}, 65'h0);

    // Watchdog: no source data for TIMEOUT cycles.
    src_valid = 1'b0;
    start_job(1'b0, 17'h0100, 16'd4);
    tick();
    repeat (1023) tick();
    check("wd_not_yet", err_timeout, 1'b0);
    tick();
    check("wd_timeout", err_timeout, 1'b1);
    src_valid = 1'b1;
    #1;
    check("wd_ack_forced", dev_ack, 1'b0);
    start_job(1'b0, 17'h0200, 16'd2);
    check("wd_start_ignored", {rqst, err_timeout}, 2'b01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("wd_reset", {err_timeout, busy}, 2'b00);
    start_job(1'b0, 17'h0200, 16'd2);
    check("wd_recover", rqst, 1'b1);
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
